// File: rtl/mul_issue_queue.sv
// mul_issue_queue
//
// Operand queue and issue controller that sits directly in front of the
// 32x32 Booth/CSA multiplier. Operand pairs arrive from a valid/ready
// producer and are buffered in a small circular queue. They are then handed
// to the multiplier one at a time through a registered en/op1/op2 interface.
//
// The multiplier ignores en in the cycle after it accepts one. Every issue is
// therefore followed by a one-cycle gap. When WAIT_RESULT is set, the
// controller also waits until the multiplier's val has been seen before it
// issues again. This gives each result a clean, isolated val pulse.
//
// Parameters:
//   DEPTH        queue entries (power of two, >= 2)
//   PTR_W        log2(DEPTH)
//   WAIT_RESULT  1 = hold the next issue until mul_val has been observed
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous active-low reset
//   flush     synchronous queue clear; has priority over push and issue
//   in_valid  producer has an operand pair
//   in_ready  queue can accept (not full)
//   in_op1    multiplicand
//   in_op2    multiplier
//   mul_en    registered one-cycle issue strobe to the multiplier
//   mul_op1   registered operand 1; holds its last issued value
//   mul_op2   registered operand 2; holds its last issued value
//   mul_val   result-valid from the multiplier
//   count     current queue occupancy
//   busy      queue non-empty or controller not idle

module mul_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2,
    parameter bit WAIT_RESULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    output logic             mul_en,
    output logic [31:0]      mul_op1,
    output logic [31:0]      mul_op2,
    input  logic             mul_val,
    output logic [PTR_W:0]   count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        WAITV
    } state_t;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

    state_t           state;
    state_t           state_next;
    logic [31:0]      mem_op1 [DEPTH];
    logic [31:0]      mem_op2 [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push;
    logic             issue;

    // A flush drops any push that arrives in the same cycle.
    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready && !flush;
    assign busy     = (count != '0) || (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and issue decision. An entry issues only from IDLE.
    // The GAP state covers the multiplier's dead cycle after accepting en.
    // WAITV requires mul_val to be high while in that state. The multiplier
    // clears val on the edge that accepts en, so a stale val cannot be seen.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        issue      = 1'b1;
                        state_next = GAP;
                    end
                end
                GAP: begin
                    state_next = WAIT_RESULT ? WAITV : IDLE;
                end
                WAITV: begin
                    if (mul_val) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Queue pointers and occupancy. A push and a pop in the same cycle leave
    // count unchanged. Both pointers still advance and wrap naturally at
    // DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ONE_PTR;
            end
            if (issue) begin
                rptr <= rptr + ONE_PTR;
            end
            case ({push, issue})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Entry storage. There is no reset, because occupancy alone says which
    // slots are live. A slot is never written and read in the same cycle: a
    // read needs count > 0, and a write needs count < DEPTH, so wptr and
    // rptr differ whenever both happen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op1[wptr] <= in_op1;
            mem_op2[wptr] <= in_op2;
        end
    end

    // Registered multiplier interface. The head entry is loaded on the same
    // edge that raises mul_en. The operands hold their value otherwise, and a
    // flush does not clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_en  <= 1'b0;
            mul_op1 <= '0;
            mul_op2 <= '0;
        end else if (flush) begin
            mul_en <= 1'b0;
        end else begin
            mul_en <= issue;
            if (issue) begin
                mul_op1 <= mem_op1[rptr];
                mul_op2 <= mem_op2[rptr];
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_queue.sv
// tb_mul_issue_queue
//
// Directed bench for mul_issue_queue. It uses two instances that share all
// inputs:
//   dut0  WAIT_RESULT=0, issues every second cycle
//   dut1  WAIT_RESULT=1, waits for mul_val between issues
// Each scenario task resets both instances and then checks the instance it
// targets against hand-derived cycle timelines. Edges are counted from the
// first rising edge after reset is released (edge 1). Outputs are sampled
// 1 time unit after each rising edge.

module tb_mul_issue_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic        mul_val;

    logic        in_ready0, mul_en0, busy0;
    logic [31:0] mul_op1_0, mul_op2_0;
    logic [2:0]  count0;

    logic        in_ready1, mul_en1, busy1;
    logic [31:0] mul_op1_1, mul_op2_1;
    logic [2:0]  count1;

    int checks;
    int failures;

    // Operand pairs used by the no-wait scenarios, in push order.
    logic [31:0] p_op1 [6];
    logic [31:0] p_op2 [6];

    mul_issue_queue #(.DEPTH(4), .PTR_W(2), .WAIT_RESULT(1'b0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .mul_en   (mul_en0),
        .mul_op1  (mul_op1_0),
        .mul_op2  (mul_op2_0),
        .mul_val  (mul_val),
        .count    (count0),
        .busy     (busy0)
    );

    mul_issue_queue #(.DEPTH(4), .PTR_W(2), .WAIT_RESULT(1'b1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .mul_en   (mul_en1),
        .mul_op1  (mul_op1_1),
        .mul_op2  (mul_op2_1),
        .mul_val  (mul_val),
        .count    (count1),
        .busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset low for two cycles and releases it just after a rising
    // edge. The next rising edge is therefore edge 1.
    task automatic do_reset();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_op1   = '0;
        in_op2   = '0;
        mul_val  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count0 !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count0);
        end
        checks++;
        if (mul_en0 !== 1'b0 || mul_op1_0 !== 32'd0 || mul_op2_0 !== 32'd0) begin
            failures++;
            $display("FAIL reset_mul got en=%b op1=%0h op2=%0h exp en=0 op1=0 op2=0",
                     mul_en0, mul_op1_0, mul_op2_0);
        end
        checks++;
        if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_busy got rdy0=%b busy0=%b rdy1=%b busy1=%b exp 1 0 1 0",
                     in_ready0, busy0, in_ready1, busy1);
        end
    endtask

    // Push (3,5) at edge 1. mul_en must be high only between edges 2 and 3.
    task automatic test_single();
        do_reset();
        in_valid = 1'b1;
        in_op1   = 32'd3;
        in_op2   = 32'd5;
        step();
        in_valid = 1'b0;
        checks++;
        if (count0 !== 3'd1 || mul_en0 !== 1'b0) begin
            failures++;
            $display("FAIL single_e1 got count=%0d en=%b exp count=1 en=0", count0, mul_en0);
        end
        step();
        checks++;
        if (mul_en0 !== 1'b1 || mul_op1_0 !== 32'd3 || mul_op2_0 !== 32'd5 || count0 !== 3'd0) begin
            failures++;
            $display("FAIL single_e2 got en=%b op1=%0d op2=%0d count=%0d exp en=1 op1=3 op2=5 count=0",
                     mul_en0, mul_op1_0, mul_op2_0, count0);
        end
        step();
        checks++;
        if (mul_en0 !== 1'b0 || mul_op1_0 !== 32'd3 || mul_op2_0 !== 32'd5) begin
            failures++;
            $display("FAIL single_e3_hold got en=%b op1=%0d op2=%0d exp en=0 op1=3 op2=5",
                     mul_en0, mul_op1_0, mul_op2_0);
        end
        mul_val = 1'b1;
        step();
        mul_val = 1'b0;
        step();
        checks++;
        if (busy0 !== 1'b0 || mul_en0 !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got busy=%b en=%b exp busy=0 en=0", busy0, mul_en0);
        end
    endtask

    // Six pairs pushed on edges 1..6 into dut0. The issues land on even edges
    // 2..12. Count after each edge: 1,1,2,2,3,3,3,2,2,1,1,0,0,0.
    task automatic test_back_to_back();
        logic [2:0] exp_count [14];
        int         k;
        exp_count = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
                      3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        k = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            in_valid = (c <= 6);
            in_op1   = (c <= 6) ? p_op1[c-1] : 32'd0;
            in_op2   = (c <= 6) ? p_op2[c-1] : 32'd0;
            step();
            checks++;
            if (count0 !== exp_count[c-1] || in_ready0 !== 1'b1) begin
                failures++;
                $display("FAIL b2b_count edge=%0d got count=%0d rdy=%b exp count=%0d rdy=1",
                         c, count0, in_ready0, exp_count[c-1]);
            end
            checks++;
            if (mul_en0 !== ((c % 2 == 0) && (c <= 12))) begin
                failures++;
                $display("FAIL b2b_en edge=%0d got=%b exp=%b", c, mul_en0,
                         (c % 2 == 0) && (c <= 12));
            end
            if ((c % 2 == 0) && (c <= 12)) begin
                checks++;
                if (mul_op1_0 !== p_op1[k] || mul_op2_0 !== p_op2[k]) begin
                    failures++;
                    $display("FAIL b2b_ops idx=%0d got op1=%0h op2=%0h exp op1=%0h op2=%0h",
                             k, mul_op1_0, mul_op2_0, p_op1[k], p_op2[k]);
                end
                k++;
            end
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_end got=%b exp=0", busy0);
        end
    endtask

    // dut1: b0 pushed at edge 1 and issued at edge 2; b1 pushed at edge 2.
    // mul_val stays low through edge 7 and is high only for edge 8, so b1
    // must issue exactly at edge 9.
    task automatic test_wait_result();
        do_reset();
        in_valid = 1'b1;
        in_op1   = 32'hB000_0000;
        in_op2   = 32'h0000_B000;
        step();
        in_op1 = 32'hB000_0001;
        in_op2 = 32'h0000_B001;
        step();
        in_valid = 1'b0;
        checks++;
        if (mul_en1 !== 1'b1 || mul_op1_1 !== 32'hB000_0000 || count1 !== 3'd1) begin
            failures++;
            $display("FAIL wait_first got en=%b op1=%0h count=%0d exp en=1 op1=b0000000 count=1",
                     mul_en1, mul_op1_1, count1);
        end
        for (int c = 3; c <= 8; c++) begin
            mul_val = (c == 8);
            step();
            checks++;
            if (mul_en1 !== 1'b0 || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL wait_hold edge=%0d got en=%b busy=%b exp en=0 busy=1",
                         c, mul_en1, busy1);
            end
        end
        mul_val = 1'b0;
        step();
        checks++;
        if (mul_en1 !== 1'b1 || mul_op1_1 !== 32'hB000_0001 || mul_op2_1 !== 32'h0000_B001
            || count1 !== 3'd0) begin
            failures++;
            $display("FAIL wait_second got en=%b op1=%0h op2=%0h count=%0d exp en=1 op1=b0000001 op2=b001 count=0",
                     mul_en1, mul_op1_1, mul_op2_1, count1);
        end
    endtask

    // dut1 fills up while mul_val is low. It reaches count 4 after edge 5,
    // and a5 is held on the input. mul_val is high for edge 7 only. a1
    // issues at edge 8, and a5 is accepted at edge 9. With mul_val then held
    // high, a2..a5 drain on edges 11, 14, 17 and 20 (3-cycle spacing). a4
    // and a5 sit in wrapped slots.
    task automatic test_full_wrap();
        int k;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            in_valid = 1'b1;
            in_op1   = 32'hA000_0000 + 32'((c <= 5) ? c - 1 : 5);
            in_op2   = 32'h0B00_0000 + 32'((c <= 5) ? c - 1 : 5);
            mul_val  = (c == 7);
            step();
            if (c == 5 || c == 6 || c == 7) begin
                checks++;
                if (count1 !== 3'd4 || in_ready1 !== 1'b0 || mul_en1 !== 1'b0) begin
                    failures++;
                    $display("FAIL full_hold edge=%0d got count=%0d rdy=%b en=%b exp count=4 rdy=0 en=0",
                             c, count1, in_ready1, mul_en1);
                end
            end
            if (c == 8) begin
                checks++;
                if (mul_en1 !== 1'b1 || mul_op1_1 !== 32'hA000_0001 || count1 !== 3'd3
                    || in_ready1 !== 1'b1) begin
                    failures++;
                    $display("FAIL full_issue got en=%b op1=%0h count=%0d rdy=%b exp en=1 op1=a0000001 count=3 rdy=1",
                             mul_en1, mul_op1_1, count1, in_ready1);
                end
            end
        end
        checks++;
        if (count1 !== 3'd4 || in_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL full_refill got count=%0d rdy=%b exp count=4 rdy=0", count1, in_ready1);
        end
        in_valid = 1'b0;
        mul_val  = 1'b1;
        k = 2;
        for (int c = 10; c <= 22; c++) begin
            step();
            checks++;
            if (mul_en1 !== ((c - 11) % 3 == 0 && c >= 11 && c <= 20)) begin
                failures++;
                $display("FAIL drain_en edge=%0d got=%b exp=%b", c, mul_en1,
                         (c - 11) % 3 == 0 && c >= 11 && c <= 20);
            end
            if ((c - 11) % 3 == 0 && c >= 11 && c <= 20) begin
                checks++;
                if (mul_op1_1 !== 32'hA000_0000 + 32'(k) || mul_op2_1 !== 32'h0B00_0000 + 32'(k)) begin
                    failures++;
                    $display("FAIL drain_ops idx=%0d got op1=%0h op2=%0h exp op1=%0h op2=%0h",
                             k, mul_op1_1, mul_op2_1, 32'hA000_0000 + 32'(k), 32'h0B00_0000 + 32'(k));
                end
                k++;
            end
        end
        mul_val = 1'b0;
        checks++;
        if (count1 !== 3'd0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL drain_end got count=%0d busy=%b exp count=0 busy=0", count1, busy1);
        end
    endtask

    // dut0 after edge 5 holds count=3 in IDLE and would issue p2 at edge 6.
    // flush arrives with a push at edge 6, so both are dropped. The operands
    // keep p1.
    task automatic test_flush();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            in_valid = 1'b1;
            in_op1   = p_op1[c-1];
            in_op2   = p_op2[c-1];
            step();
        end
        checks++;
        if (count0 !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre_count got=%0d exp=3", count0);
        end
        flush  = 1'b1;
        in_op1 = p_op1[5];
        in_op2 = p_op2[5];
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count0 !== 3'd0 || mul_en0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got count=%0d en=%b rdy=%b busy=%b exp 0 0 1 0",
                     count0, mul_en0, in_ready0, busy0);
        end
        checks++;
        if (mul_op1_0 !== p_op1[1] || mul_op2_0 !== p_op2[1]) begin
            failures++;
            $display("FAIL flush_ops_hold got op1=%0h op2=%0h exp op1=%0h op2=%0h",
                     mul_op1_0, mul_op2_0, p_op1[1], p_op2[1]);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (mul_en0 !== 1'b0 || count0 !== 3'd0) begin
                failures++;
                $display("FAIL flush_after cyc=%0d got en=%b count=%0d exp en=0 count=0",
                         c, mul_en0, count0);
            end
        end
    endtask

    // dut0 after edge 4 has just issued p1, is in GAP, and holds count=2.
    // Pulling reset low between edges must clear the outputs without waiting
    // for a clock edge.
    task automatic test_reset_mid_gap();
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            in_valid = 1'b1;
            in_op1   = p_op1[c-1];
            in_op2   = p_op2[c-1];
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count0 !== 3'd2 || mul_en0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got count=%0d en=%b exp count=2 en=1", count0, mul_en0);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (mul_en0 !== 1'b0 || count0 !== 3'd0 || in_ready0 !== 1'b1 || mul_op1_0 !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_async got en=%b count=%0d rdy=%b op1=%0h exp en=0 count=0 rdy=1 op1=0",
                     mul_en0, count0, in_ready0, mul_op1_0);
        end
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (mul_en0 !== 1'b0 || count0 !== 3'd0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after cyc=%0d got en=%b count=%0d busy=%b exp 0 0 0",
                         c, mul_en0, count0, busy0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        p_op1 = '{32'h0000_0011, 32'h0000_0022, 32'hFFFF_FFFF,
                  32'h1234_5678, 32'h8000_0000, 32'h0000_0007};
        p_op2 = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0001,
                  32'h9ABC_DEF0, 32'h7FFF_FFFF, 32'h0000_0009};
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_result();
        test_full_wrap();
        test_flush();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
